// File: rtl/rv32i_ctrl_pkg.sv
// Shared encodings for the rv32i multicycle controller: opcodes, ALU ops,
// FSM state codes and data-path mux selects.
package rv32i_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_EQ  = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [3:0] RESET_STATE = S_FETCH;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_for(input logic [6:0] opc);
        case (opc)
            OP_STORE:  imm_for = IMM_S;
            OP_BRANCH: imm_for = IMM_B;
            OP_JAL:    imm_for = IMM_J;
            default:   imm_for = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-op decode from (opcode, funct3, funct7_5), flagging
// funct combinations the data path does not implement.
module alu_decoder
    import rv32i_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] operation,
    output logic       op_illegal
);

    always_comb begin
        operation  = ALU_ADD;
        op_illegal = 1'b0;
        if (opcode == OP_RTYPE || opcode == OP_ITYPE) begin
            case (funct3)
                3'b000:  operation = (opcode == OP_RTYPE && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b111:  operation = ALU_AND;
                3'b110:  operation = ALU_OR;
                3'b010:  operation = ALU_SLT;
                default: op_illegal = 1'b1;
            endcase
        end else if (opcode == OP_BRANCH) begin
            // Only beq/bne are supported by the equality compare.
            operation  = ALU_EQ;
            op_illegal = (funct3[2:1] != 2'b00);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle rv32i control FSM: Moore-decoded data-path controls, with the
// branch PC write resolved combinationally from the ALU compare flag.
module multicycle_control
    import rv32i_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       alu_flag,
    output logic [2:0] operation,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic [1:0] imm_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    logic [3:0] state, next_state, cur;
    logic [2:0] dec_op;
    logic       dec_illegal;
    logic       known_op;

    alu_decoder u_alu_decoder (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .operation  (dec_op),
        .op_illegal (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= RESET_STATE;
        else     state <= next_state;
    end

    // While reset is held the outputs present FETCH, with all strobes masked.
    assign cur       = rst ? RESET_STATE : state;
    assign state_dbg = state;

    always_comb begin
        case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: known_op = 1'b1;
            default: known_op = 1'b0;
        endcase
    end

    always_comb begin
        operation  = ALU_ADD;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        adr_src    = 1'b0;
        imm_src    = imm_for(opcode);
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        illegal    = 1'b0;
        next_state = S_FETCH;
        case (cur)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALU;
                pc_write   = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                if (!known_op || dec_illegal) begin
                    illegal = 1'b1;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: next_state = S_MEMADR;
                        OP_RTYPE:          next_state = S_EXECR;
                        OP_ITYPE:          next_state = S_EXECI;
                        OP_BRANCH:         next_state = S_BRANCH;
                        default:           next_state = S_JAL;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a  = SRC_A_RS1;
                operation  = dec_op;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                operation  = dec_op;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                operation = ALU_EQ;
                // funct3[0] distinguishes bne from beq.
                pc_write  = alu_flag ^ funct3[0];
            end
            S_JAL: begin
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
        if (rst) begin
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule
